aes_encr_seq: RTL and testbench

Iterative AES-128 encryption sequencer. It reuses one round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) for ten clock cycles and generates round keys on the fly, one per cycle. It replaces the fully unrolled combinational encryptor where area matters, and sits between the SoC bus interface (valid/ready on both sides) and the crypto result path.

---
 rtl/aes_encr_seq.sv | 185 ++++++++++++++++++
 tb/tb_aes_encr_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encr_seq.sv
// Iterative AES-128 encryptor: one shared round datapath runs for ten cycles,
// and each round key is derived from the previous one in the same cycle.
module aes_encr_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       r_fsm;
  state_t       w_fsmNext;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [3:0]   r_round;
  logic         r_outValid;
  logic [127:0] r_outData;

  logic [127:0] w_rkNext;
  logic [127:0] w_shifted;
  logic [127:0] w_mixed;
  logic [127:0] w_roundOut;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] keyStep(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;
    w3   = rk[31:0];
    temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    n0   = rk[127:96] ^ temp;
    n1   = rk[95:64] ^ n0;
    n2   = rk[63:32] ^ n1;
    n3   = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign w_rkNext   = keyStep(r_rk, rcon(r_round));
  assign w_shifted  = shiftRows(subBytes(r_state));
  assign w_mixed    = mixColumns(w_shifted);
  // The final round drops MixColumns.
  assign w_roundOut = ((r_round == 4'd10) ? w_shifted : w_mixed) ^ w_rkNext;

  assign in_ready  = (r_fsm == IDLE);
  assign busy      = (r_fsm != IDLE);
  assign out_valid = r_outValid;
  assign out_data  = r_outData;

  always_ff @(posedge clk) begin
    if (!rst) r_fsm <= IDLE;
    else      r_fsm <= w_fsmNext;
  end

  always_comb begin
    w_fsmNext = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid) w_fsmNext = ROUND;
      ROUND:   if (r_round == 4'd10) w_fsmNext = DONE;
      DONE:    if (r_outValid && out_ready) w_fsmNext = IDLE;
      default: w_fsmNext = IDLE;
    endcase
  end

  // Inputs are captured only on the accept edge; the result register loads on the last round.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= '0;
      r_rk       <= '0;
      r_round    <= 4'd1;
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= in_data ^ in_key;
            r_rk    <= in_key;
            r_round <= 4'd1;
          end
        end
        ROUND: begin
          r_state <= w_roundOut;
          r_rk    <= w_rkNext;
          if (r_round == 4'd10) begin
            r_round    <= 4'd1;
            r_outData  <= w_roundOut;
            r_outValid <= 1'b1;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) r_outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encr_seq.sv
// Directed and randomized checks of aes_encr_seq against a byte-level AES-128
// reference model with a full precomputed key schedule.
module tb_aes_encr_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] sboxTab [256];

  aes_encr_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table built by walking the multiplicative group with generator 3.
  task automatic buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sboxTab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxTab[0] = 8'h63;
  endtask

  function automatic logic [127:0] aesRef(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sboxTab[tmp[23:16]], sboxTab[tmp[15:8]], sboxTab[tmp[7:0]], sboxTab[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ key[127-8*j -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sboxTab[s[j]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int c = 0; c < 4; c++) begin
        tmp = w[4*r+c];
        s[4*c]   ^= tmp[31:24];
        s[4*c+1] ^= tmp[23:16];
        s[4*c+2] ^= tmp[15:8];
        s[4*c+3] ^= tmp[7:0];
      end
    end
    res = '0;
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one block in IDLE, then counts cycles until out_valid (bounded).
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt,
                               input bit scramble, output int latency);
    in_key   = key;
    in_data  = pt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    latency  = 0;
    while (!out_valid && latency < 50) begin
      if (scramble) begin
        in_key  = rand128();
        in_data = rand128();
      end
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] k, p, exp, newK, newP;
    logic [127:0] keys [4];
    logic [127:0] pts  [4];
    logic [127:0] expQ [$];
    int           acceptCyc [$];
    int           lat, idx, got, cyc;
    bit           wasAccept, sawValid;

    buildSbox();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] FIPS-197 C.1");
    applyStimulus(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 0, lat);
    checkOutput("c1_latency", lat, 10);
    checkOutput("c1_data", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    checkOutput("c1_busy", busy, 1);
    checkOutput("c1_in_ready", in_ready, 0);
    handshake();
    checkOutput("c1_valid_drop", out_valid, 0);
    checkOutput("c1_ready_back", in_ready, 1);

    $display("[TB] FIPS-197 B");
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 0, lat);
    checkOutput("b_latency", lat, 10);
    checkOutput("b_data", out_data, 128'h3925841d02dc09fbdc118597196a0b32);
    checkOutput("b_rk10", dut.r_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    handshake();

    $display("[TB] backpressure");
    k = rand128(); p = rand128(); exp = aesRef(k, p);
    newK = rand128(); newP = rand128();
    applyStimulus(k, p, 0, lat);
    checkOutput("bp_latency", lat, 10);
    in_key = newK; in_data = newP;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_data", out_data, exp);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b1;
    handshake();
    checkOutput("bp_idle_ready", in_ready, 1);
    checkOutput("bp_idle_busy", busy, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_accept_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp_new_latency", lat, 10);
    checkOutput("bp_new_data", out_data, aesRef(newK, newP));
    handshake();

    $display("[TB] back-to-back");
    for (int i = 0; i < 4; i++) begin
      keys[i] = rand128();
      pts[i]  = rand128();
    end
    idx = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    in_key = keys[0]; in_data = pts[0]; in_valid = 1'b1;
    while (got < 4 && cyc < 300) begin
      wasAccept = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      if (wasAccept) begin
        acceptCyc.push_back(cyc);
        expQ.push_back(aesRef(keys[idx], pts[idx]));
        idx++;
        if (idx < 4) begin
          in_key  = keys[idx];
          in_data = pts[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && expQ.size() > 0) begin
        checkOutput("b2b_data", out_data, expQ.pop_front());
        got++;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("b2b_count", got, 4);
    checkOutput("b2b_accepts", acceptCyc.size(), 4);
    for (int i = 1; i < acceptCyc.size(); i++)
      checkOutput("b2b_interval", acceptCyc[i] - acceptCyc[i-1], 12);

    $display("[TB] mid-operation reset");
    in_key = rand128(); in_data = rand128(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checkOutput("mr_out_valid", out_valid, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_in_ready", in_ready, 1);
    sawValid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("mr_no_output", sawValid, 0);
    applyStimulus(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 0, lat);
    checkOutput("mr_c1_latency", lat, 10);
    checkOutput("mr_c1_data", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    handshake();

    $display("[TB] input stability");
    for (int n = 0; n < 3; n++) begin
      k = rand128(); p = rand128();
      applyStimulus(k, p, 1, lat);
      checkOutput("stab_latency", lat, 10);
      checkOutput("stab_data", out_data, aesRef(k, p));
      handshake();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
